// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Measures the period and high time of an asynchronous PWM
//               waveform in clk cycles. A measurement is taken between two
//               consecutive rising edges of the synchronized input. If no
//               edge arrives before the period counter saturates, a timeout
//               measurement is reported with meas_ovf set.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH        width of the cycle counters and measurement outputs
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   pwm_in       asynchronous PWM input
//   cfg_en       capture enable; low forces the IDLE state
//   meas_period  clk cycles between the last two rising edges
//   meas_high    clk cycles pwm_in was high within that period
//   meas_valid   one-cycle strobe; measurement outputs update on this cycle
//   meas_ovf     measurement came from a timeout rather than an edge
// ============================================================================
module pwm_capture #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             cfg_en,
  output logic [WIDTH-1:0] meas_period,
  output logic [WIDTH-1:0] meas_high,
  output logic             meas_valid,
  output logic             meas_ovf
);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    STALL = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronizer and edge detector
  // --------------------------------------------------------------------------
  logic sync1_q, sync1_d;
  logic s_q,     s_d;       // synchronized pwm_in
  logic s_dly_q, s_dly_d;   // s delayed by one cycle
  logic rise;

  always_comb begin
    sync1_d = pwm_in;
    s_d     = sync1_q;
    s_dly_d = s_q;
  end

  assign rise = s_q & ~s_dly_q;

  // --------------------------------------------------------------------------
  // FSM, counters and capture stage
  // --------------------------------------------------------------------------
  state_t           state_q,     state_d;
  logic [WIDTH-1:0] cnt_per_q,   cnt_per_d;
  logic [WIDTH-1:0] cnt_hi_q,    cnt_hi_d;
  logic [WIDTH-1:0] cnt_per_inc;
  logic [WIDTH-1:0] cnt_hi_inc;

  // The capture stage holds a completed measurement for one cycle before it
  // reaches the outputs, which sets the edge-to-strobe latency.
  logic             cap_valid_q, cap_valid_d;
  logic [WIDTH-1:0] cap_per_q,   cap_per_d;
  logic [WIDTH-1:0] cap_hi_q,    cap_hi_d;
  logic             cap_ovf_q,   cap_ovf_d;

  // Saturating increments: counters stick at CNT_MAX instead of wrapping.
  assign cnt_per_inc = (cnt_per_q == CNT_MAX) ? CNT_MAX : cnt_per_q + CNT_ONE;
  assign cnt_hi_inc  = (cnt_hi_q  == CNT_MAX) ? CNT_MAX : cnt_hi_q  + CNT_ONE;

  always_comb begin
    state_d     = state_q;
    cnt_per_d   = cnt_per_q;
    cnt_hi_d    = cnt_hi_q;
    cap_valid_d = 1'b0;
    cap_per_d   = cap_per_q;
    cap_hi_d    = cap_hi_q;
    cap_ovf_d   = cap_ovf_q;

    if (!cfg_en) begin
      // Disabling aborts any measurement in progress without a strobe.
      state_d   = IDLE;
      cnt_per_d = CNT_ZERO;
      cnt_hi_d  = CNT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = ARM;
          cnt_per_d = CNT_ZERO;
          cnt_hi_d  = CNT_ZERO;
        end

        // The first edge after arming (or after a timeout) only starts a
        // period; there is nothing to report yet.
        ARM, STALL: begin
          if (rise) begin
            state_d   = RUN;
            cnt_per_d = CNT_ONE;
            cnt_hi_d  = CNT_ONE;
          end
        end

        RUN: begin
          if (rise) begin
            // An edge takes priority over a simultaneous saturation.
            cap_valid_d = 1'b1;
            cap_per_d   = cnt_per_q;
            cap_hi_d    = cnt_hi_q;
            cap_ovf_d   = 1'b0;
            cnt_per_d   = CNT_ONE;
            cnt_hi_d    = CNT_ONE;
          end else if (cnt_per_q == CNT_MAX) begin
            // Timeout: report a saturated period; the high time is either
            // all of it or none of it depending on the current level.
            cap_valid_d = 1'b1;
            cap_per_d   = CNT_MAX;
            cap_hi_d    = s_q ? CNT_MAX : CNT_ZERO;
            cap_ovf_d   = 1'b1;
            state_d     = STALL;
          end else begin
            cnt_per_d = cnt_per_inc;
            if (s_q) begin
              cnt_hi_d = cnt_hi_inc;
            end
          end
        end

        default: begin
          state_d   = IDLE;
          cnt_per_d = CNT_ZERO;
          cnt_hi_d  = CNT_ZERO;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output registers: update only when a capture is presented.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] meas_period_q, meas_period_d;
  logic [WIDTH-1:0] meas_high_q,   meas_high_d;
  logic             meas_valid_q,  meas_valid_d;
  logic             meas_ovf_q,    meas_ovf_d;

  always_comb begin
    meas_valid_d  = cap_valid_q;
    meas_period_d = meas_period_q;
    meas_high_d   = meas_high_q;
    meas_ovf_d    = meas_ovf_q;
    if (cap_valid_q) begin
      meas_period_d = cap_per_q;
      meas_high_d   = cap_hi_q;
      meas_ovf_d    = cap_ovf_q;
    end
  end

  // --------------------------------------------------------------------------
  // State registers. Reset clears the whole pipeline so that no strobe can
  // emerge on the reset cycle or the one after it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      s_q           <= 1'b0;
      s_dly_q       <= 1'b0;
      state_q       <= IDLE;
      cnt_per_q     <= CNT_ZERO;
      cnt_hi_q      <= CNT_ZERO;
      cap_valid_q   <= 1'b0;
      cap_per_q     <= CNT_ZERO;
      cap_hi_q      <= CNT_ZERO;
      cap_ovf_q     <= 1'b0;
      meas_period_q <= CNT_ZERO;
      meas_high_q   <= CNT_ZERO;
      meas_valid_q  <= 1'b0;
      meas_ovf_q    <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      s_q           <= s_d;
      s_dly_q       <= s_dly_d;
      state_q       <= state_d;
      cnt_per_q     <= cnt_per_d;
      cnt_hi_q      <= cnt_hi_d;
      cap_valid_q   <= cap_valid_d;
      cap_per_q     <= cap_per_d;
      cap_hi_q      <= cap_hi_d;
      cap_ovf_q     <= cap_ovf_d;
      meas_period_q <= meas_period_d;
      meas_high_q   <= meas_high_d;
      meas_valid_q  <= meas_valid_d;
      meas_ovf_q    <= meas_ovf_d;
    end
  end

  assign meas_period = meas_period_q;
  assign meas_high   = meas_high_q;
  assign meas_valid  = meas_valid_q;
  assign meas_ovf    = meas_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_capture
// Description : Self-checking bench for pwm_capture (WIDTH=10). The stimulus
//               process pushes each expected measurement, including the
//               cycle on which its strobe must appear, into a queue; the
//               monitor pops and compares on every meas_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

  localparam int WIDTH = 10;
  localparam int MAXV  = 1023;

  logic             clk;
  logic             rst;
  logic             pwm_in;
  logic             cfg_en;
  logic [WIDTH-1:0] meas_period;
  logic [WIDTH-1:0] meas_high;
  logic             meas_valid;
  logic             meas_ovf;

  pwm_capture #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .cfg_en      (cfg_en),
    .meas_period (meas_period),
    .meas_high   (meas_high),
    .meas_valid  (meas_valid),
    .meas_ovf    (meas_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int per;
    int hi;
    int ovf;
    int at;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   last_rise = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      chk("no_back_to_back_strobe", int'(prev_valid), 0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got period=%0d high=%0d ovf=%0d at cycle %0d, expected no strobe",
                 meas_period, meas_high, meas_ovf, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_cycle", cyc, e.at);
        chk("meas_period", int'(meas_period), e.per);
        chk("meas_high", int'(meas_high), e.hi);
        chk("meas_ovf", int'(meas_ovf), e.ovf);
      end
    end
    prev_valid = meas_valid;
  end

  // ---------------- stimulus helpers (called at negedge) ----------------
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise pwm_in. When exp_strobe is set, the period that this edge closes
  // must be reported four cycles later.
  task automatic rise(input bit exp_strobe, input int per, input int hi);
    exp_t e;
    pwm_in    = 1'b1;
    last_rise = cyc;
    if (exp_strobe) begin
      e.per = per; e.hi = hi; e.ovf = 0; e.at = cyc + 4;
      q.push_back(e);
    end
  endtask

  task automatic push_timeout(input int hi);
    exp_t e;
    e.per = MAXV; e.hi = hi; e.ovf = 1; e.at = last_rise + 4 + MAXV;
    q.push_back(e);
  endtask

  task automatic pulse(input bit exp_strobe, input int per, input int hi,
                       input int h, input int l);
    rise(exp_strobe, per, hi);
    hold(h);
    pwm_in = 1'b0;
    hold(l);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_period"}, int'(meas_period), 0);
    chk({tag, "_high"},   int'(meas_high),   0);
    chk({tag, "_valid"},  int'(meas_valid),  0);
    chk({tag, "_ovf"},    int'(meas_ovf),    0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst    = 1'b1;
    cfg_en = 1'b0;
    pwm_in = 1'b0;
    hold(3);
    chk_zero_outputs("reset");
    rst    = 1'b0;
    cfg_en = 1'b1;
    hold(5);

    // 100-cycle period, 25 high: first rise silent, then every rise reports.
    pulse(1'b0, 0, 0, 25, 75);
    for (int i = 0; i < 4; i++) begin
      pulse(1'b1, 100, 25, 25, 75);
    end

    // Last rise then low forever: exactly one low-level timeout.
    rise(1'b1, 100, 25);
    push_timeout(0);
    hold(25);
    pwm_in = 1'b0;
    hold(1100);

    // Recovery from STALL: next edge pair gives a normal capture.
    pulse(1'b0, 0, 0, 10, 40);
    rise(1'b1, 50, 10);

    // Held high after a rise: high-level timeout.
    push_timeout(MAXV);
    hold(1100);
    pwm_in = 1'b0;
    hold(20);

    // Period exactly 1023: edge coincides with saturation and wins.
    pulse(1'b0, 0, 0, 100, 923);
    rise(1'b1, 1023, 100);
    hold(40);
    pwm_in = 1'b0;
    hold(20);
    // Still in RUN: the following edge reports a normal 60-cycle period.
    rise(1'b1, 60, 40);

    // cfg_en dropped 10 cycles after a rise, then raised again.
    hold(10);
    cfg_en = 1'b0;
    hold(10);
    pwm_in = 1'b0;
    hold(20);
    cfg_en = 1'b1;
    hold(10);
    pulse(1'b0, 0, 0, 15, 45);
    rise(1'b1, 60, 15);
    hold(15);
    pwm_in = 1'b0;
    hold(20);

    // Reset mid-period: outputs cleared, nothing until two new rises.
    rst = 1'b1;
    hold(1);
    chk_zero_outputs("mid_reset");
    rst = 1'b0;
    hold(25);
    pulse(1'b0, 0, 0, 15, 45);
    rise(1'b1, 60, 15);
    hold(15);
    pwm_in = 1'b0;
    hold(10);
    cfg_en = 1'b0;
    hold(30);

    // Any expectation still queued is a strobe that never arrived.
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_strobe: got none, expected period=%0d high=%0d ovf=%0d at cycle %0d",
               e.per, e.hi, e.ovf, e.at);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
- REQ-001: Parameter WIDTH, default 10, sets the width of the counters and measurement outputs in bits.
- REQ-002: clk  input  1  sole clock; all logic is on its rising edge.
- REQ-003: rst  input  1  synchronous, active-high reset.
- REQ-004: pwm_in  input  1  asynchronous PWM waveform to be measured.
- REQ-005: cfg_en  input  1  capture enable; 0 forces the IDLE state.
- REQ-006: meas_period  output  WIDTH  clk cycles between the last two rising edges.
- REQ-007: meas_high  output  WIDTH  clk cycles pwm_in was high within that period.
- REQ-008: meas_valid  output  1  one-cycle strobe; meas_period, meas_high and meas_ovf are updated on this cycle.
- REQ-009: meas_ovf  output  1  1 = measurement came from a timeout, not from an edge.

Function
- REQ-010: pwm_in shall pass through a 2-FF synchronizer giving s, then one delay register giving s_d.
- REQ-011: rise = s & ~s_d.
- REQ-012: The FSM shall have exactly four states: IDLE, ARM, RUN and STALL.
- REQ-013: IDLE: entered whenever cfg_en=0; counters are held at 0; the state moves to ARM when cfg_en=1.
- REQ-014: ARM: on rise the FSM goes to RUN, the counters are loaded, and no meas_valid is issued, because the first edge carries no period.
- REQ-015: Counter cnt_per (WIDTH bits): loaded with 1 on rise, otherwise incremented, saturating at 2^WIDTH-1.
- REQ-016: Counter cnt_hi (WIDTH bits): loaded with 1 on rise, otherwise incremented when s=1, saturating at 2^WIDTH-1.
- REQ-017: RUN, on rise: meas_period<=cnt_per, meas_high<=cnt_hi, meas_ovf<=0, meas_valid=1 for one cycle, counters reloaded per REQ-015 and REQ-016.
- REQ-018: RUN, with cnt_per=2^WIDTH-1 and no rise: meas_period<=2^WIDTH-1, meas_high<=(s ? 2^WIDTH-1 : 0), meas_ovf<=1, meas_valid=1 for one cycle, then go to STALL.
- REQ-019: STALL: no further meas_valid is issued; on rise the FSM behaves as ARM (goes to RUN, no strobe).
- REQ-020: A rise in the same cycle that cnt_per is saturated shall win: normal capture per REQ-017 with meas_ovf=0.
- REQ-021: Latency: a pwm_in 0->1 transition first sampled at clk edge k shall produce meas_valid asserted after edge k+3.
- REQ-022: A measurement of a period P>=2 and high time H, with 1<=H<P, stable across two rises and with P<2^WIDTH, shall be exact.
- REQ-023: cfg_en 1->0 mid-measurement shall abort it: state IDLE on the next cycle, no strobe.
- REQ-024: meas_period, meas_high and meas_ovf shall hold their last value through IDLE, ARM and STALL.
- REQ-025: meas_valid shall never be high on two consecutive cycles.

Reset
- REQ-026: rst=1 shall set state IDLE, synchronizer and s_d to 0, cnt_per=cnt_hi=0, meas_period=meas_high=0, meas_valid=0, meas_ovf=0.
- REQ-027: rst asserted mid-measurement shall override every other event, with no strobe on that cycle or the one after.

Verification (WIDTH=10)
- REQ-028: cfg_en=1, pwm_in period 100 cycles, high 25 -> no strobe on the first rise; from the second rise on, each strobe has period=100, high=25, ovf=0.
- REQ-029: pwm_in toggling, then held low -> exactly one strobe, 1023 cycles after the last rise, with period=1023, high=0, ovf=1; then no strobes; next edge pair gives a normal capture.
- REQ-030: pwm_in held high after a rise -> one strobe with period=1023, high=1023, ovf=1.
- REQ-031: Period exactly 1023 cycles, rise coinciding with saturation -> strobe with period=1023, ovf=0, FSM stays in RUN.
- REQ-032: cfg_en dropped 10 cycles after a rise, then raised -> no strobe until the second rise after re-enable.
- REQ-033: rst pulsed mid-period -> all outputs 0 and meas_valid low until re-armed and two rises are seen.
